// File: rtl/p_alu_issue_queue.sv
// ALU reservation station: compacting age-ordered queue with CDB wakeup,
// oldest-ready-first issue, and all-or-nothing two-slot dispatch intake.
`ifndef ROB_WIDTH
`define ROB_WIDTH 6
`endif

module p_alu_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ROB_W     = `ROB_WIDTH,
  parameter int PAYLOAD_W = 64,
  localparam int CW       = $clog2(DEPTH + 1),
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  input  logic [1:0]             in_mask_i,
  output logic                   in_ready_o,
  input  logic [2*ROB_W-1:0]     in_dst_i,
  input  logic [2*PAYLOAD_W-1:0] in_payload_i,
  input  logic [4*ROB_W-1:0]     in_src_tag_i,
  input  logic [3:0]             in_src_rdy_i,
  input  logic [127:0]           in_src_data_i,
  input  logic [1:0]             cdb_valid_i,
  input  logic [2*ROB_W-1:0]     cdb_preg_i,
  input  logic [63:0]            cdb_data_i,
  output logic                   iss_valid_o,
  input  logic                   iss_ready_i,
  output logic [ROB_W-1:0]       iss_dst_o,
  output logic [PAYLOAD_W-1:0]   iss_payload_o,
  output logic [63:0]            iss_src_data_o,
  output logic [CW-1:0]          count_o
);

  typedef struct packed {
    logic                       valid;
    logic [ROB_W-1:0]           dst;
    logic [PAYLOAD_W-1:0]       payload;
    logic [1:0][ROB_W-1:0]      tag;
    logic [1:0]                 rdy;
    logic [1:0][31:0]           data;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  entry_t        woke  [DEPTH];
  entry_t        mid   [DEPTH];
  entry_t        inc   [2];
  logic [CW-1:0] count_q, count_d, cnt_mid, wr0, wr1;
  logic [IW-1:0] sel_idx;
  logic          sel_found, do_issue, accept;

  // Port 1 is applied last so it wins a double match.
  function automatic entry_t wake(entry_t e, logic [1:0] v,
                                  logic [2*ROB_W-1:0] tags, logic [63:0] d);
    entry_t r = e;
    for (int s = 0; s < 2; s++) begin
      if (e.valid && !e.rdy[s]) begin
        for (int p = 0; p < 2; p++) begin
          if (v[p] && tags[p*ROB_W +: ROB_W] == e.tag[s]) begin
            r.rdy[s]  = 1'b1;
            r.data[s] = d[p*32 +: 32];
          end
        end
      end
    end
    return r;
  endfunction

  assign in_ready_o     = (count_q <= CW'(DEPTH - 2));
  assign count_o        = count_q;
  assign iss_valid_o    = sel_found;
  assign iss_dst_o      = ent_q[sel_idx].dst;
  assign iss_payload_o  = ent_q[sel_idx].payload;
  assign iss_src_data_o = ent_q[sel_idx].data;

  // NOTE: every variable here gets a default before any conditional update,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && (&ent_q[i].rdy)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    do_issue = sel_found & iss_ready_i;

    for (int i = 0; i < DEPTH; i++) woke[i] = wake(ent_q[i], cdb_valid_i, cdb_preg_i, cdb_data_i);

    // Entries above the issued one slide down to keep index 0 the oldest.
    mid = woke;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_issue && i >= int'(sel_idx)) mid[i] = woke[i+1];
    end
    if (do_issue) mid[DEPTH-1] = '0;
    cnt_mid = count_q - CW'(do_issue);

    for (int s = 0; s < 2; s++) begin
      inc[s]         = '0;
      inc[s].valid   = 1'b1;
      inc[s].dst     = in_dst_i[s*ROB_W +: ROB_W];
      inc[s].payload = in_payload_i[s*PAYLOAD_W +: PAYLOAD_W];
      for (int k = 0; k < 2; k++) begin
        inc[s].tag[k]  = in_src_tag_i[(2*s+k)*ROB_W +: ROB_W];
        inc[s].rdy[k]  = in_src_rdy_i[2*s+k];
        inc[s].data[k] = in_src_data_i[(2*s+k)*32 +: 32];
      end
      inc[s] = wake(inc[s], cdb_valid_i, cdb_preg_i, cdb_data_i);
    end

    accept  = in_valid_i & in_ready_o;
    wr0     = cnt_mid;
    wr1     = cnt_mid + CW'(in_mask_i[0]);
    ent_d   = mid;
    count_d = cnt_mid;
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (in_mask_i[0] && CW'(i) == wr0) ent_d[i] = inc[0];
        if (in_mask_i[1] && CW'(i) == wr1) ent_d[i] = inc[1];
      end
      count_d = cnt_mid + CW'(in_mask_i[0]) + CW'(in_mask_i[1]);
    end

    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      count_d = '0;
    end
  end

  // NOTE: only the valid bits and the count are reset; the tag/data/payload
  // storage is don't-care while invalid and is always written before use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  a_cdb_no_dup_tag: assert property (@(posedge clk) disable iff (!rst_n)
    !(cdb_valid_i == 2'b11 && cdb_preg_i[0 +: ROB_W] == cdb_preg_i[ROB_W +: ROB_W]));

endmodule

// File: tb/tb_p_alu_issue_queue.sv
// Directed self-checking bench for p_alu_issue_queue (DEPTH=8, ROB_W=6).
module tb_p_alu_issue_queue;

  localparam int DEPTH = 8;
  localparam int RW    = 6;
  localparam int PW    = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, flush_i, in_valid_i, in_ready_o, iss_valid_o, iss_ready_i;
  logic [1:0]       in_mask_i, cdb_valid_i;
  logic [2*RW-1:0]  in_dst_i, cdb_preg_i;
  logic [2*PW-1:0]  in_payload_i;
  logic [4*RW-1:0]  in_src_tag_i;
  logic [3:0]       in_src_rdy_i;
  logic [127:0]     in_src_data_i;
  logic [63:0]      cdb_data_i, iss_src_data_o;
  logic [RW-1:0]    iss_dst_o;
  logic [PW-1:0]    iss_payload_o;
  logic [CW-1:0]    count_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  p_alu_issue_queue #(.DEPTH(DEPTH), .ROB_W(RW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_mask_i(in_mask_i), .in_ready_o(in_ready_o),
    .in_dst_i(in_dst_i), .in_payload_i(in_payload_i), .in_src_tag_i(in_src_tag_i),
    .in_src_rdy_i(in_src_rdy_i), .in_src_data_i(in_src_data_i),
    .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i), .cdb_data_i(cdb_data_i),
    .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i), .iss_dst_o(iss_dst_o),
    .iss_payload_o(iss_payload_o), .iss_src_data_o(iss_src_data_o), .count_o(count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_valid_i    = 1'b0;
    in_mask_i     = 2'b00;
    in_dst_i      = '0;
    in_payload_i  = '0;
    in_src_tag_i  = '0;
    in_src_rdy_i  = '0;
    in_src_data_i = '0;
    cdb_valid_i   = 2'b00;
    cdb_preg_i    = '0;
    cdb_data_i    = '0;
    flush_i       = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [RW-1:0] dst, input logic [63:0] pay,
                          input logic [RW-1:0] t0, input logic r0, input logic [31:0] d0,
                          input logic [RW-1:0] t1, input logic r1, input logic [31:0] d1);
    in_dst_i[s*RW +: RW]             = dst;
    in_payload_i[s*PW +: PW]         = pay;
    in_src_tag_i[(2*s)*RW +: RW]     = t0;
    in_src_tag_i[(2*s+1)*RW +: RW]   = t1;
    in_src_rdy_i[2*s]                = r0;
    in_src_rdy_i[2*s+1]              = r1;
    in_src_data_i[(2*s)*32 +: 32]    = d0;
    in_src_data_i[(2*s+1)*32 +: 32]  = d1;
  endtask

  // Ready op in the given slot; payload mirrors dst for easy tracking.
  task automatic ready_slot(input int s, input logic [RW-1:0] dst);
    set_slot(s, dst, 64'(dst) + 64'h1000, 6'd0, 1'b1, 32'(dst), 6'd0, 1'b1, 32'(dst) + 32'h100);
  endtask

  initial begin
    clear_in();
    iss_ready_i = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_iss_valid", 64'(iss_valid_o), 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready_o), 64'd1);

    // 1: ready op issues the cycle after enqueue
    iss_ready_i = 1'b1;
    set_slot(0, 6'd5, 64'hCAFE_0005, 6'd0, 1'b1, 32'h11, 6'd0, 1'b1, 32'h22);
    in_valid_i = 1'b1; in_mask_i = 2'b01;
    step();
    clear_in();
    check("t1_valid", 64'(iss_valid_o), 64'd1);
    check("t1_dst", 64'(iss_dst_o), 64'd5);
    check("t1_payload", iss_payload_o, 64'hCAFE_0005);
    check("t1_srcdata", iss_src_data_o, 64'h0000_0022_0000_0011);
    check("t1_count1", 64'(count_o), 64'd1);
    step();
    check("t1_count0", 64'(count_o), 64'd0);
    check("t1_empty", 64'(iss_valid_o), 64'd0);

    // 2: wakeup from a stored entry via CDB port 0
    set_slot(0, 6'd3, 64'h3, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h33);
    in_valid_i = 1'b1; in_mask_i = 2'b01;
    step();
    clear_in();
    check("t2_wait1", 64'(iss_valid_o), 64'd0);
    step();
    check("t2_wait2", 64'(iss_valid_o), 64'd0);
    cdb_valid_i = 2'b01; cdb_preg_i[0 +: RW] = 6'd9; cdb_data_i[31:0] = 32'hDEAD;
    check("t2_not_same_cycle", 64'(iss_valid_o), 64'd0);
    step();
    clear_in();
    check("t2_valid", 64'(iss_valid_o), 64'd1);
    check("t2_dst", 64'(iss_dst_o), 64'd3);
    check("t2_src0", 64'(iss_src_data_o[31:0]), 64'hDEAD);
    check("t2_src1", 64'(iss_src_data_o[63:32]), 64'h33);
    step();
    check("t2_count0", 64'(count_o), 64'd0);

    // 3: pair held by back-pressure, oldest first
    iss_ready_i = 1'b0;
    ready_slot(0, 6'd10);
    ready_slot(1, 6'd11);
    in_valid_i = 1'b1; in_mask_i = 2'b11;
    step();
    clear_in();
    check("t3_count2", 64'(count_o), 64'd2);
    step();
    step();
    check("t3_hold_dst", 64'(iss_dst_o), 64'd10);
    check("t3_hold_count", 64'(count_o), 64'd2);
    iss_ready_i = 1'b1;
    step();
    check("t3_second_dst", 64'(iss_dst_o), 64'd11);
    check("t3_count1", 64'(count_o), 64'd1);
    step();
    check("t3_count0", 64'(count_o), 64'd0);

    // 4: fill to DEPTH-1, rejected group, issue frees space, ordered drain
    iss_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ready_slot(0, 6'(20 + 2*k));
      ready_slot(1, 6'(21 + 2*k));
      in_valid_i = 1'b1; in_mask_i = 2'b11;
      step();
    end
    clear_in();
    check("t4_count6", 64'(count_o), 64'd6);
    check("t4_ready_at6", 64'(in_ready_o), 64'd1);
    ready_slot(0, 6'd26);
    in_valid_i = 1'b1; in_mask_i = 2'b01;
    step();
    check("t4_count7", 64'(count_o), 64'd7);
    check("t4_full", 64'(in_ready_o), 64'd0);
    ready_slot(0, 6'd40);
    ready_slot(1, 6'd41);
    in_mask_i = 2'b11;
    step();
    clear_in();
    check("t4_no_overflow", 64'(count_o), 64'd7);
    check("t4_oldest", 64'(iss_dst_o), 64'd20);
    iss_ready_i = 1'b1;
    step();
    iss_ready_i = 1'b0;
    check("t4_count_after_issue", 64'(count_o), 64'd6);
    check("t4_ready_again", 64'(in_ready_o), 64'd1);
    iss_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_drain%0d", k), 64'(iss_dst_o), 64'(21 + k));
      step();
    end
    check("t4_drained", 64'(count_o), 64'd0);

    // 5: bypass wakeup on port 1 during the accept cycle
    set_slot(0, 6'd12, 64'h12, 6'd0, 1'b1, 32'h44, 6'd7, 1'b0, 32'h0);
    in_valid_i = 1'b1; in_mask_i = 2'b01;
    cdb_valid_i = 2'b10; cdb_preg_i[RW +: RW] = 6'd7; cdb_data_i[63:32] = 32'hBEEF;
    step();
    clear_in();
    check("t5_valid", 64'(iss_valid_o), 64'd1);
    check("t5_src1", 64'(iss_src_data_o[63:32]), 64'hBEEF);
    check("t5_src0", 64'(iss_src_data_o[31:0]), 64'h44);
    step();
    check("t5_count0", 64'(count_o), 64'd0);

    // mask 2'b10 takes only slot1; mask 2'b00 is a no-op
    iss_ready_i = 1'b0;
    ready_slot(0, 6'd31);
    ready_slot(1, 6'd30);
    in_valid_i = 1'b1; in_mask_i = 2'b10;
    step();
    check("m10_count", 64'(count_o), 64'd1);
    check("m10_dst", 64'(iss_dst_o), 64'd30);
    in_mask_i = 2'b00;
    step();
    check("m00_count", 64'(count_o), 64'd1);
    // simultaneous issue + enqueue keeps the count
    iss_ready_i = 1'b1;
    ready_slot(0, 6'd42);
    in_mask_i = 2'b01;
    step();
    clear_in();
    check("swap_count", 64'(count_o), 64'd1);
    check("swap_dst", 64'(iss_dst_o), 64'd42);
    step();
    check("swap_count0", 64'(count_o), 64'd0);

    // 6: flush with a same-cycle enqueue, then reset mid-stream
    iss_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ready_slot(0, 6'(50 + 2*k));
      ready_slot(1, 6'(51 + 2*k));
      in_valid_i = 1'b1; in_mask_i = 2'b11;
      step();
    end
    check("t6_count4", 64'(count_o), 64'd4);
    ready_slot(0, 6'd60);
    ready_slot(1, 6'd61);
    flush_i = 1'b1;
    step();
    clear_in();
    check("t6_flush_count", 64'(count_o), 64'd0);
    check("t6_flush_valid", 64'(iss_valid_o), 64'd0);
    check("t6_flush_ready", 64'(in_ready_o), 64'd1);
    for (int k = 0; k < 2; k++) begin
      ready_slot(0, 6'(50 + 2*k));
      ready_slot(1, 6'(51 + 2*k));
      in_valid_i = 1'b1; in_mask_i = 2'b11;
      step();
    end
    clear_in();
    check("t6_refill", 64'(count_o), 64'd4);
    rst_n = 1'b0;
    ready_slot(0, 6'd62);
    in_valid_i = 1'b1; in_mask_i = 2'b01;
    step();
    clear_in();
    rst_n = 1'b1;
    check("t6_rst_count", 64'(count_o), 64'd0);
    check("t6_rst_valid", 64'(iss_valid_o), 64'd0);
    step();
    check("t6_rst_ready", 64'(in_ready_o), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
